// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle CPU: sequences fetch/decode/execute/writeback,
// drives FlagsWrite to the conditional unit and gates architectural writes with CondEx.
module multicycle_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    input  logic               CondEx,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               AdrSrc,
    output logic [1:0]         ResultSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUControl,
    output logic [1:0]         FlagsWrite,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cmd;
    logic [1:0] alu_dec;
    logic       cmd_known, cmd_cmp, cmd_arith, dp_wr;

    assign cmd = Funct[4:1];

    // Unknown commands execute as ADD but must not change any architectural state.
    always_comb begin
        alu_dec   = 2'b00;
        cmd_known = 1'b1;
        cmd_cmp   = 1'b0;
        cmd_arith = 1'b0;
        case (cmd)
            4'b0100: begin alu_dec = 2'b00; cmd_arith = 1'b1; end
            4'b0010: begin alu_dec = 2'b01; cmd_arith = 1'b1; end
            4'b0000: alu_dec = 2'b10;
            4'b1100: alu_dec = 2'b11;
            4'b1010: begin alu_dec = 2'b01; cmd_cmp = 1'b1; cmd_arith = 1'b1; end
            default: cmd_known = 1'b0;
        endcase
    end

    assign dp_wr = CondEx & cmd_known & ~cmd_cmp;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = MemReady ? S_FETCH : S_MEMWR;
            S_EXECR,
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Reset forces every enable and select low so an aborted instruction leaves no trace.
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        FlagsWrite = 2'b00;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
                    IRWrite = MemReady; PCWrite = MemReady;
                end
                S_DECODE: begin
                    ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
                end
                S_MEMADR: ALUSrcB = 2'b01;
                S_MEMRD:  AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = CondEx;
                    PCWrite   = CondEx & (Rd == 4'd15);
                end
                S_MEMWR: begin
                    AdrSrc = 1'b1; MemWrite = CondEx;
                end
                S_EXECR: ALUControl = alu_dec;
                S_EXECI: begin
                    ALUSrcB = 2'b01; ALUControl = alu_dec;
                end
                S_ALUWB: begin
                    ALUControl = alu_dec;
                    RegWrite   = dp_wr;
                    PCWrite    = dp_wr & (Rd == 4'd15);
                    if (cmd_cmp)        FlagsWrite = 2'b11;
                    else if (cmd_known) FlagsWrite = {Funct[0], Funct[0] & cmd_arith};
                end
                S_BRANCH: begin
                    ALUSrcB = 2'b01; ResultSrc = 2'b10; PCWrite = CondEx;
                end
                default: ;
            endcase
        end
    end

    assign State = STATE_W'(state_q);

endmodule
